mcs4_fetch_seq: RTL
===================

MCS4_FETCH_SEQ -- requirements
Module: mcs4_fetch_seq

Interface
REQ-001 SHALL provide parameter: RESET_PC, 12'h000, program counter value loaded on reset.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port: en  input  1  advance enable; cycle phase and all state hold when 0.
REQ-005 SHALL provide port: data_in  input  4  ROM data-bus nibble.
REQ-006 SHALL provide port: pc_load_valid  input  1  jump request, sampled at X3 only.
REQ-007 SHALL provide port: pc_load_addr  input  12  jump target.
REQ-008 SHALL provide port: data_out  output  4  address nibble driven to bus.
REQ-009 SHALL provide port: data_oe  output  1  bus drive enable.
REQ-010 SHALL provide port: sync  output  1  high during X3 phase.
REQ-011 SHALL provide port: cyc  output  3  current phase, mcs4::instr_cyc_t encoding (A1=0 .. X3=7).
REQ-012 SHALL provide port: pc  output  12  address of instruction being fetched.
REQ-013 SHALL provide port: instr  output  8  captured instruction, mcs4::instr_t {opr,opa}.
REQ-014 SHALL provide port: instr_valid  output  1  one-clock strobe, instr is complete.
REQ-015 SHALL provide port: second_word  output  1  current fetch is second byte of two-word instruction.

Function
REQ-016 SHALL advance cyc A1->A2->A3->M1->M2->X1->X2->X3->A1 on each clk with en=1; hold with en=0.
REQ-017 SHALL drive data_out = pc[3:0] in A1, pc[7:4] in A2, pc[11:8] in A3, 4'h0 otherwise; data_oe=1 in A1-A3 only.
REQ-018 SHALL capture data_in into instr.opr on the M1 clock with en=1, and into instr.opa on the M2 clock with en=1.
REQ-019 SHALL assert instr_valid exactly in cycles where cyc==X1 and en=1 (one pulse per instruction byte).
REQ-020 SHALL assert sync combinationally whenever cyc==X3.
REQ-021 SHALL update pc on the X3->A1 transition: pc_load_addr if pc_load_valid=1, else pc+1, wrapping 12'hFFF->12'h000.
REQ-022 SHALL ignore pc_load_valid in all phases other than X3 with en=1; load takes precedence over increment.
REQ-023 SHALL classify a captured byte as two-word when opr in {JCN, JUN, JMS, ISZ}, or opr==FIM_SRC with opa[0]=0.
REQ-024 SHALL set second_word at X3->A1 when second_word=0 and the captured byte is two-word; otherwise clear it at X3->A1.
REQ-025 SHALL not decode a byte fetched with second_word=1 (no chained two-word detection).
REQ-026 SHALL keep second_word set even when pc_load_valid is applied at the first word's X3 (second byte fetched from load target).

Reset
REQ-027 SHALL on rst_n=0 at clk edge set cyc=A1, pc=RESET_PC, instr=8'h00, second_word=0, regardless of en.
REQ-028 SHALL force data_oe=0, sync=0, instr_valid=0, data_out=4'h0 while rst_n=0; first post-reset cycle is A1 with data_oe=1.
REQ-029 SHALL abandon any partial instruction on reset mid-cycle; no instr_valid for it.

Configuration
REQ-030 SHALL, with MCS4_FETCH_ICOUNT_EN defined, add output instr_count (16 bits) counting instr_valid strobes with second_word=0, saturating at 16'hFFFF, reset to 0.
REQ-031 SHALL, without MCS4_FETCH_ICOUNT_EN, omit instr_count port and its logic entirely.

Verification
REQ-032 SHALL test: reset, en=1, RESET_PC=12'h000, ROM returns 8'hD5 -> instr=8'hD5, instr_valid at clk 6, second_word=0, pc=12'h001 at next A1.
REQ-033 SHALL test: byte 8'h40 (JUN) then 8'h23 -> second_word=1 during second fetch, cleared after; pc_load_valid=1, addr 12'h023 at second X3 -> next A1 drives 3,2,0.
REQ-034 SHALL test: byte 8'h22 (FIM) -> second_word=1; byte 8'h21 (SRC) -> second_word stays 0.
REQ-035 SHALL test: pc=12'hFFF, no load -> next pc=12'h000; pc_load_valid pulsed at M1 -> ignored.
REQ-036 SHALL test: en=0 for 3 clocks at M2 -> cyc, pc, instr frozen, no extra instr_valid; rst_n=0 at X1 -> cyc=A1, pc=RESET_PC next clk, no instr_valid.
REQ-037 SHALL test (MCS4_FETCH_ICOUNT_EN): 3 instructions incl. one JUN pair -> instr_count=3; preload near 16'hFFFF -> saturates.

Source files
------------

// File: rtl/mcs4_fetch_seq.sv
// -----------------------------------------------------------------------------
// mcs4_fetch_seq
//
// Purpose:
//   MCS-4 style instruction fetch sequencer. Walks the eight-phase machine
//   cycle A1 A2 A3 M1 M2 X1 X2 X3. It drives the 12-bit program counter onto
//   the 4-bit bus during A1..A3 and captures the instruction nibbles during
//   M1/M2. It strobes instr_valid in X1 and raises sync in X3. The PC advances
//   (or jumps) on the X3->A1 transition. Two-word instructions are tracked so
//   that their second byte is flagged and not decoded again.
//
// Parameters:
//   RESET_PC       program counter value loaded on reset
//
// Ports:
//   clk            single clock, all state updates on rising edge
//   rst_n          synchronous active-low reset
//   en             advance enable; phase and all state hold when low
//   data_in[3:0]   ROM data-bus nibble
//   pc_load_valid  jump request, honoured only in X3 with en=1
//   pc_load_addr   jump target
//   data_out[3:0]  address nibble driven to the bus (A1..A3), else 0
//   data_oe        bus drive enable (A1..A3)
//   sync           high during X3
//   cyc[2:0]       current phase, A1=0 .. X3=7
//   pc[11:0]       address of the instruction byte being fetched
//   instr[7:0]     captured byte {opr, opa}
//   instr_valid    one-clock strobe in X1 (with en=1): instr is complete
//   second_word    current fetch is the second byte of a two-word instruction
//   instr_count    (only with MCS4_FETCH_ICOUNT_EN) saturating count of
//                  instruction-start strobes (instr_valid with second_word=0)
//
// Build option:
//   `define MCS4_FETCH_ICOUNT_EN to add the instr_count output and its counter.
// -----------------------------------------------------------------------------
module mcs4_fetch_seq #(
  parameter logic [11:0] RESET_PC = 12'h000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [3:0]  data_in,
  input  logic        pc_load_valid,
  input  logic [11:0] pc_load_addr,
  output logic [3:0]  data_out,
  output logic        data_oe,
  output logic        sync,
  output logic [2:0]  cyc,
  output logic [11:0] pc,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic        second_word
`ifdef MCS4_FETCH_ICOUNT_EN
  ,
  output logic [15:0] instr_count
`endif
);

  typedef enum logic [2:0] {
    CYC_A1 = 3'd0,
    CYC_A2 = 3'd1,
    CYC_A3 = 3'd2,
    CYC_M1 = 3'd3,
    CYC_M2 = 3'd4,
    CYC_X1 = 3'd5,
    CYC_X2 = 3'd6,
    CYC_X3 = 3'd7
  } cyc_e;

  // OPR codes of instructions that occupy two bytes. FIM and SRC share an
  // OPR and are told apart by opa[0] (FIM when 0).
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_ISZ     = 4'h7;

  cyc_e        cyc_q, cyc_d;
  logic [11:0] pc_q, pc_d;
  logic [7:0]  instr_q, instr_d;
  logic        second_word_q, second_word_d;
  logic        two_word;

  // Classification of the byte captured during this machine cycle.
  always_comb begin
    two_word = 1'b0;
    unique case (instr_q[7:4])
      OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two_word = 1'b1;
      OPR_FIM_SRC:                        two_word = ~instr_q[0];
      default:                            two_word = 1'b0;
    endcase
  end

  always_comb begin
    cyc_d         = cyc_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    second_word_d = second_word_q;
    if (en) begin
      // X3 wraps naturally to A1 in 3-bit arithmetic.
      cyc_d = cyc_e'(cyc_q + 3'd1);
      unique case (cyc_q)
        CYC_M1: instr_d = {data_in, instr_q[3:0]};
        CYC_M2: instr_d = {instr_q[7:4], data_in};
        CYC_X3: begin
          pc_d = pc_load_valid ? pc_load_addr : pc_q + 12'd1;
          // A second byte is never decoded, so a jump target whose bytes
          // look like another two-word opcode cannot chain. A jump taken at
          // the first word's X3 still fetches the second byte (from the
          // target), so the flag ignores pc_load_valid.
          second_word_d = ~second_word_q & two_word;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q         <= CYC_A1;
      pc_q          <= RESET_PC;
      instr_q       <= 8'h00;
      second_word_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      second_word_q <= second_word_d;
    end
  end

  // Bus-facing outputs are decoded from the registered phase and gated by
  // rst_n so that nothing is driven while reset is held.
  always_comb begin
    data_out = 4'h0;
    if (rst_n) begin
      unique case (cyc_q)
        CYC_A1:  data_out = pc_q[3:0];
        CYC_A2:  data_out = pc_q[7:4];
        CYC_A3:  data_out = pc_q[11:8];
        default: data_out = 4'h0;
      endcase
    end
  end

  assign data_oe     = rst_n & ((cyc_q == CYC_A1) | (cyc_q == CYC_A2) | (cyc_q == CYC_A3));
  assign sync        = rst_n & (cyc_q == CYC_X3);
  assign instr_valid = rst_n & en & (cyc_q == CYC_X1);

  assign cyc         = cyc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign second_word = second_word_q;

`ifdef MCS4_FETCH_ICOUNT_EN
  logic [15:0] icount_q, icount_d;

  // Counts instruction starts only: the second byte of a pair is not counted.
  always_comb begin
    icount_d = icount_q;
    if (instr_valid && !second_word_q && (icount_q != 16'hFFFF)) begin
      icount_d = icount_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icount_q <= 16'h0000;
    end else begin
      icount_q <= icount_d;
    end
  end

  assign instr_count = icount_q;
`endif

endmodule
